instr_fetch: RTL and testbench

- Fetch stage directly downstream of the program-counter register.
- Reads the current PC, runs one variable-latency req/ack read on the instruction-memory port and captures the word in an instruction register (IR).
- Presents IR plus its PC to decode over a valid/ready handshake.
- Returns a one-cycle pc_en to the PC register's EN input, so the PC advances only when a fetch completes.

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_wdog.sv | 31 +++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP word and
// alignment helper used by the instruction fetch unit.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] & INSTR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Saturating bus-timeout counter for the fetch unit.
// expire flags the last permitted cycle of an unanswered request.
module fetch_wdog #(
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one req/ack read per PC, result held in
// IR and handed to decode over valid/ready; pc_en advances the PC.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        fetch_err
);

    fetch_state_t state, state_n;

    logic        req_n;
    logic [31:0] addr_n;
    logic [31:0] ir_n;
    logic [31:0] ir_pc_n;
    logic        valid_n;
    logic        pc_en_n;
    logic        err_n;
    logic        wd_clr;
    logic        wd_en;
    logic        wd_expire;
    logic        xfer;

    fetch_wdog #(
        .BUS_TIMEOUT(BUS_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    assign wd_en = (state == REQ) || (state == DROP);
    assign xfer  = ir_valid && ir_ready && !flush;

    always_comb begin
        state_n = state;
        req_n   = imem_req;
        addr_n  = imem_addr;
        ir_n    = ir;
        ir_pc_n = ir_pc;
        valid_n = ir_valid;
        pc_en_n = 1'b0;
        err_n   = fetch_err;
        wd_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    err_n = 1'b0;
                end else if (fetch_err) begin
                    state_n = IDLE;
                end else if (!is_aligned(pc)) begin
                    err_n = 1'b1;
                end else begin
                    addr_n  = pc;
                    req_n   = 1'b1;
                    wd_clr  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (imem_ack && flush) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (flush) begin
                    // The bus cannot abort: keep requesting, discard later.
                    state_n = DROP;
                end else if (imem_ack) begin
                    ir_n    = imem_rdata;
                    ir_pc_n = imem_addr;
                    valid_n = 1'b1;
                    req_n   = 1'b0;
                    pc_en_n = 1'b1;
                    state_n = HOLD;
                end else if (wd_expire) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (xfer) begin
                    valid_n = 1'b0;
                    if (is_aligned(pc)) begin
                        addr_n  = pc;
                        req_n   = 1'b1;
                        wd_clr  = 1'b1;
                        state_n = REQ;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (wd_expire) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir        <= NOP;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            pc_en     <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            ir        <= ir_n;
            ir_pc     <= ir_pc_n;
            ir_valid  <= valid_n;
            pc_en     <= pc_en_n;
            fetch_err <= err_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    instr_fetch #(.BUS_TIMEOUT(255), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .pc_en     (pc_en),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .flush     (flush),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "[TB] aborted");
    end

    task automatic do_reset(input logic [31:0] p);
        @(negedge clk);
        rst_n = 1'b0; pc = p; imem_ack = 1'b0; imem_rdata = '0;
        flush = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; pc = 32'h0; imem_ack = 1'b0; imem_rdata = '0;
        flush = 1'b0; ir_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        tests++; if (ir !== 32'h0) begin fails++; $display("FAIL rst_ir: got %h want 0", ir); end
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
        tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    endtask

    task automatic test_basic_fetch();
        do_reset(32'h0);
        @(negedge clk);
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL basic_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr: got %h want 0", imem_addr); end
        tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL basic_pc_en_early: got %b want 0", pc_en); end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++; if (ir !== 32'h2008_0005) begin fails++; $display("FAIL basic_ir: got %h want 20080005", ir); end
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL basic_ir_pc: got %h want 0", ir_pc); end
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", ir_valid); end
        tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL basic_pc_en: got %b want 1", pc_en); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL basic_req_drop: got %b want 0", imem_req); end
        @(negedge clk);
        tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL basic_pc_en_once: got %b want 0", pc_en); end
    endtask

    task automatic test_stall();
        int bad;
        do_reset(32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        @(negedge clk);
        imem_ack = 1'b0; pc = 32'h4;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ir_valid !== 1'b1 || ir !== 32'h2008_0005 || imem_req !== 1'b0 || pc_en !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL stall_next_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h4) begin fails++; $display("FAIL stall_next_addr: got %h want 4", imem_addr); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL stall_consumed: got %b want 0", ir_valid); end
        tests++; if (ir !== 32'h2008_0005) begin fails++; $display("FAIL stall_ir_kept: got %h want 20080005", ir); end
        imem_ack = 1'b1; imem_rdata = 32'h8C09_0004;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++; if (ir !== 32'h8C09_0004) begin fails++; $display("FAIL stall_ir2: got %h want 8c090004", ir); end
        tests++; if (ir_pc !== 32'h4) begin fails++; $display("FAIL stall_ir_pc2: got %h want 4", ir_pc); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset(32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000; ir_ready = 1'b1;
        @(negedge clk);
        pulses = (pc_en === 1'b1) ? 1 : 0;
        tests++; if (ir !== 32'h1111_0000) begin fails++; $display("FAIL b2b_ir0: got %h want 11110000", ir); end
        pc = 32'h4; imem_rdata = 32'h2222_0004;
        @(negedge clk);
        if (pc_en === 1'b1) pulses++;
        tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++; $display("FAIL b2b_req1: got req %b addr %h want 1 00000004", imem_req, imem_addr); end
        @(negedge clk);
        if (pc_en === 1'b1) pulses++;
        tests++; if (ir !== 32'h2222_0004 || ir_pc !== 32'h4) begin fails++; $display("FAIL b2b_ir1: got %h@%h want 22220004@00000004", ir, ir_pc); end
        tests++; if (pulses !== 2) begin fails++; $display("FAIL b2b_pc_en_count: got %0d want 2", pulses); end
        imem_ack = 1'b0; ir_ready = 1'b0;
    endtask

    task automatic test_flush_req();
        int bad;
        do_reset(32'h8);
        @(negedge clk);
        tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL flreq_addr: got %h want 8", imem_addr); end
        flush = 1'b1; pc = 32'h40;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL flreq_req_held: got %0d bad cycles want 0", bad); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++; if (ir_valid !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL flreq_discard: got valid %b pc_en %b want 0 0", ir_valid, pc_en); end
        tests++; if (ir !== 32'h0 || imem_req !== 1'b0) begin fails++; $display("FAIL flreq_nocap: got ir %h req %b want 0 0", ir, imem_req); end
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL flreq_refetch: got req %b addr %h want 1 00000040", imem_req, imem_addr); end
    endtask

    task automatic test_flush_ack();
        do_reset(32'h10);
        @(negedge clk);
        imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'h1234_5678; pc = 32'h20;
        @(negedge clk);
        imem_ack = 1'b0; flush = 1'b0;
        tests++; if (ir_valid !== 1'b0 || pc_en !== 1'b0 || ir !== 32'h0) begin fails++; $display("FAIL flack_nocap: got valid %b pc_en %b ir %h want 0 0 0", ir_valid, pc_en, ir); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL flack_idle: got req %b want 0", imem_req); end
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin fails++; $display("FAIL flack_refetch: got req %b addr %h want 1 00000020", imem_req, imem_addr); end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset(32'h100);
        @(negedge clk);
        bad = 0;
        for (int i = 1; i <= 254; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL to_req_held: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL to_req_drop: got %b want 0", imem_req); end
        tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", fetch_err); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || fetch_err !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL to_halted: got %0d bad cycles want 0", bad); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL to_clear: got err %b req %b want 0 0", fetch_err, imem_req); end
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL to_resume: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
    endtask

    task automatic test_misaligned();
        int bad;
        do_reset(32'h6);
        @(negedge clk);
        tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL mis_err: got %b want 1", fetch_err); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL mis_noreq: got %0d req cycles want 0", bad); end
    endtask

    task automatic test_reset_mid_req();
        do_reset(32'h200);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        imem_ack = 1'b0; ir_ready = 1'b1; pc = 32'h204;
        @(negedge clk);
        ir_ready = 1'b0;
        tests++; if (imem_req !== 1'b1 || ir !== 32'hAAAA_5555) begin fails++; $display("FAIL rmid_setup: got req %b ir %h want 1 aaaa5555", imem_req, ir); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL rmid_bus: got req %b addr %h want 0 0", imem_req, imem_addr); end
        tests++; if (ir !== 32'h0 || ir_pc !== 32'h0 || ir_valid !== 1'b0) begin fails++; $display("FAIL rmid_ir: got ir %h pc %h v %b want 0 0 0", ir, ir_pc, ir_valid); end
        tests++; if (pc_en !== 1'b0 || fetch_err !== 1'b0) begin fails++; $display("FAIL rmid_flags: got pc_en %b err %b want 0 0", pc_en, fetch_err); end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hBBBB_0000; pc = 32'h300;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++; if (ir_valid !== 1'b0 || pc_en !== 1'b0) begin fails++; $display("FAIL rmid_stale_ack: got valid %b pc_en %b want 0 0", ir_valid, pc_en); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin fails++; $display("FAIL rmid_refetch: got req %b addr %h want 1 00000300", imem_req, imem_addr); end
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; imem_ack = 1'b0; imem_rdata = '0;
        flush = 1'b0; ir_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_stall();
        test_back_to_back();
        test_flush_req();
        test_flush_ack();
        test_timeout();
        test_misaligned();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
